matrix_alloc: RTL and testbench

Matrix storage allocator that sits directly downstream of the input subsystem's dimension/address handshake.
- Accepts a dims request (m, n) held high by the input stage, validates it, and returns a 9-bit base address plus a one-cycle ready pulse.
- Keeps a directory of stored matrices: shape, base address and per-shape slot index.
- Answers lookup-by-(m, n, index) queries for the compute stage.

---
 rtl/matrix_alloc.sv | 229 ++++++++++++++++++++++
 tb/tb_matrix_alloc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alloc.sv
// Matrix storage allocator: grants base addresses for (m,n) requests and keeps a
// searchable directory of stored matrices with per-shape round-robin replacement.
module matrix_alloc #(
    parameter int unsigned MEM_DEPTH     = 512,
    parameter int unsigned DIR_DEPTH     = 16,
    parameter int unsigned MAX_PER_SHAPE = 2,
    parameter int unsigned DIM_MAX       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_all,
    input  logic        req_valid,
    input  logic [31:0] req_m,
    input  logic [31:0] req_n,
    output logic        addr_ready,
    output logic [8:0]  base_addr,
    output logic        alloc_fail,
    input  logic        query_valid,
    input  logic [31:0] query_m,
    input  logic [31:0] query_n,
    input  logic [31:0] query_idx,
    output logic        query_done,
    output logic        query_hit,
    output logic [8:0]  query_base,
    output logic [2:0]  query_cnt,
    output logic        busy,
    output logic [4:0]  dir_count
);
    localparam int unsigned DIM_W  = $clog2(DIM_MAX + 1);
    localparam int unsigned SIZE_W = $clog2(DIM_MAX * DIM_MAX + 1);
    localparam int unsigned PTR_W  = 10;
    localparam int unsigned BASE_W = 9;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DCNT_W = 5;
    localparam int unsigned IDX_W  = (DIR_DEPTH > 1) ? $clog2(DIR_DEPTH) : 1;
    localparam int unsigned SLOT_W = (MAX_PER_SHAPE > 1) ? $clog2(MAX_PER_SHAPE) : 1;
    localparam int unsigned NSHAPE = DIM_MAX * DIM_MAX;
    localparam int unsigned SH_W   = (NSHAPE > 1) ? $clog2(NSHAPE) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, DECIDE, GRANT, RESP, REARM} state_t;

    state_t state, state_next;

    logic [DIM_W-1:0]  op_m, op_n;
    logic [SLOT_W-1:0] op_slot;
    logic              op_query;
    logic [IDX_W-1:0]  scan_ptr, free_idx;
    logic              have_free, q_hit;
    logic [BASE_W-1:0] rep_base, q_base;
    logic [PTR_W-1:0]  free_ptr;

    logic              dir_valid [DIR_DEPTH];
    logic [DIM_W-1:0]  dir_m     [DIR_DEPTH];
    logic [DIM_W-1:0]  dir_n     [DIR_DEPTH];
    logic [BASE_W-1:0] dir_base  [DIR_DEPTH];
    logic [SLOT_W-1:0] dir_slot  [DIR_DEPTH];
    logic [SLOT_W-1:0] repl_ptr  [NSHAPE];
    logic [CNT_W-1:0]  shape_cnt [NSHAPE];

    function automatic logic dim_ok(input logic [31:0] d);
        return (d >= 32'd1) && (d <= 32'(DIM_MAX));
    endfunction

    function automatic logic [SH_W-1:0] shape_of(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
        return SH_W'((32'(m) - 32'd1) * 32'(DIM_MAX) + 32'(n) - 32'd1);
    endfunction

    logic              req_ok, qry_shape_ok, qry_ok, scan_last, fits;
    logic              cur_match, cur_rep, cur_q, cur_free, served_valid;
    logic [SH_W-1:0]   sh, qsh;
    logic [SIZE_W-1:0] size;

    // Operand validation and per-entry scan comparisons
    always_comb begin
        req_ok       = dim_ok(req_m) && dim_ok(req_n);
        qry_shape_ok = dim_ok(query_m) && dim_ok(query_n);
        qry_ok       = qry_shape_ok && (query_idx >= 32'd1) && (query_idx <= 32'(MAX_PER_SHAPE));
        sh           = shape_of(op_m, op_n);
        qsh          = shape_of(DIM_W'(query_m), DIM_W'(query_n));
        size         = SIZE_W'(op_m) * SIZE_W'(op_n);
        fits         = (11'(free_ptr) + 11'(size)) <= 11'(MEM_DEPTH);
        scan_last    = (scan_ptr == IDX_W'(DIR_DEPTH - 1));
        cur_match    = dir_valid[scan_ptr] && (dir_m[scan_ptr] == op_m) && (dir_n[scan_ptr] == op_n);
        cur_rep      = cur_match && (dir_slot[scan_ptr] == repl_ptr[sh]);
        cur_q        = cur_match && (dir_slot[scan_ptr] == op_slot);
        cur_free     = !dir_valid[scan_ptr] && !have_free;
        // Only the served handshake has to drop; a queued query legitimately stays high
        served_valid = op_query ? query_valid : req_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_all)        state_next = IDLE;
                else if (req_valid)   state_next = req_ok ? SCAN : GRANT;
                else if (query_valid) state_next = qry_ok ? SCAN : RESP;
            end
            SCAN:    if (scan_last) state_next = op_query ? RESP : DECIDE;
            DECIDE:  state_next = GRANT;
            GRANT:   state_next = REARM;
            RESP:    state_next = REARM;
            REARM:   if (!served_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, directory and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_ready <= 1'b0;
            base_addr  <= '0;
            alloc_fail <= 1'b0;
            query_done <= 1'b0;
            query_hit  <= 1'b0;
            query_base <= '0;
            query_cnt  <= '0;
            busy       <= 1'b0;
            dir_count  <= '0;
            op_m       <= '0;
            op_n       <= '0;
            op_slot    <= '0;
            op_query   <= 1'b0;
            scan_ptr   <= '0;
            free_idx   <= '0;
            have_free  <= 1'b0;
            q_hit      <= 1'b0;
            rep_base   <= '0;
            q_base     <= '0;
            free_ptr   <= '0;
            for (int i = 0; i < int'(DIR_DEPTH); i++) begin
                dir_valid[i] <= 1'b0;
                dir_m[i]     <= '0;
                dir_n[i]     <= '0;
                dir_base[i]  <= '0;
                dir_slot[i]  <= '0;
            end
            for (int s = 0; s < int'(NSHAPE); s++) begin
                repl_ptr[s]  <= '0;
                shape_cnt[s] <= '0;
            end
        end else begin
            addr_ready <= 1'b0;
            alloc_fail <= 1'b0;
            query_done <= 1'b0;
            busy       <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    scan_ptr  <= '0;
                    have_free <= 1'b0;
                    q_hit     <= 1'b0;
                    q_base    <= '0;
                    rep_base  <= '0;
                    if (clear_all) begin
                        free_ptr  <= '0;
                        dir_count <= '0;
                        for (int i = 0; i < int'(DIR_DEPTH); i++) dir_valid[i] <= 1'b0;
                        for (int s = 0; s < int'(NSHAPE); s++) begin
                            repl_ptr[s]  <= '0;
                            shape_cnt[s] <= '0;
                        end
                    end else if (req_valid) begin
                        op_m     <= DIM_W'(req_m);
                        op_n     <= DIM_W'(req_n);
                        op_query <= 1'b0;
                        if (!req_ok) alloc_fail <= 1'b1;
                    end else if (query_valid) begin
                        op_m     <= DIM_W'(query_m);
                        op_n     <= DIM_W'(query_n);
                        op_slot  <= SLOT_W'(query_idx - 32'd1);
                        op_query <= 1'b1;
                        if (!qry_ok) begin
                            query_done <= 1'b1;
                            query_hit  <= 1'b0;
                            query_base <= '0;
                            query_cnt  <= qry_shape_ok ? shape_cnt[qsh] : '0;
                        end
                    end
                end
                SCAN: begin
                    scan_ptr <= scan_ptr + IDX_W'(1);
                    if (cur_rep) rep_base <= dir_base[scan_ptr];
                    if (cur_q) begin
                        q_hit  <= 1'b1;
                        q_base <= dir_base[scan_ptr];
                    end
                    if (cur_free) begin
                        have_free <= 1'b1;
                        free_idx  <= scan_ptr;
                    end
                    // Last entry is folded in combinationally so the response lands one cycle earlier
                    if (scan_last && op_query) begin
                        query_done <= 1'b1;
                        query_hit  <= q_hit || cur_q;
                        query_base <= cur_q ? dir_base[scan_ptr] : q_base;
                        query_cnt  <= shape_cnt[sh];
                    end
                end
                DECIDE: begin
                    if (shape_cnt[sh] == CNT_W'(MAX_PER_SHAPE)) begin
                        addr_ready   <= 1'b1;
                        base_addr    <= rep_base;
                        repl_ptr[sh] <= (repl_ptr[sh] == SLOT_W'(MAX_PER_SHAPE - 1)) ? '0
                                                                                      : repl_ptr[sh] + SLOT_W'(1);
                    end else if (!have_free || !fits) begin
                        alloc_fail <= 1'b1;
                    end else begin
                        dir_valid[free_idx] <= 1'b1;
                        dir_m[free_idx]     <= op_m;
                        dir_n[free_idx]     <= op_n;
                        dir_base[free_idx]  <= BASE_W'(free_ptr);
                        dir_slot[free_idx]  <= SLOT_W'(shape_cnt[sh]);
                        shape_cnt[sh]       <= shape_cnt[sh] + CNT_W'(1);
                        free_ptr            <= free_ptr + PTR_W'(size);
                        dir_count           <= dir_count + DCNT_W'(1);
                        addr_ready          <= 1'b1;
                        base_addr           <= BASE_W'(free_ptr);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_alloc.sv
// Directed bench for matrix_alloc: a default instance plus a small one
// (MEM_DEPTH=32, DIR_DEPTH=4) for memory and directory exhaustion.
module tb_matrix_alloc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear_all, req_valid, query_valid, use_small;
    logic [31:0] req_m, req_n, query_m, query_n, query_idx;

    logic       ar_b, af_b, qd_b, qh_b, bs_b, ar_s, af_s, qd_s, qh_s, bs_s;
    logic [8:0] ba_b, qb_b, ba_s, qb_s;
    logic [2:0] qc_b, qc_s;
    logic [4:0] dc_b, dc_s;

    logic       addr_ready, alloc_fail, query_done, query_hit, busy;
    logic [8:0] base_addr, query_base;
    logic [2:0] query_cnt;
    logic [4:0] dir_count;

    assign addr_ready = use_small ? ar_s : ar_b;
    assign alloc_fail = use_small ? af_s : af_b;
    assign query_done = use_small ? qd_s : qd_b;
    assign query_hit  = use_small ? qh_s : qh_b;
    assign busy       = use_small ? bs_s : bs_b;
    assign base_addr  = use_small ? ba_s : ba_b;
    assign query_base = use_small ? qb_s : qb_b;
    assign query_cnt  = use_small ? qc_s : qc_b;
    assign dir_count  = use_small ? dc_s : dc_b;

    matrix_alloc u_big (
        .clk(clk), .rst(rst), .clear_all(clear_all & ~use_small),
        .req_valid(req_valid & ~use_small), .req_m(req_m), .req_n(req_n),
        .addr_ready(ar_b), .base_addr(ba_b), .alloc_fail(af_b),
        .query_valid(query_valid & ~use_small), .query_m(query_m), .query_n(query_n),
        .query_idx(query_idx), .query_done(qd_b), .query_hit(qh_b), .query_base(qb_b),
        .query_cnt(qc_b), .busy(bs_b), .dir_count(dc_b)
    );

    matrix_alloc #(.MEM_DEPTH(32), .DIR_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .clear_all(clear_all & use_small),
        .req_valid(req_valid & use_small), .req_m(req_m), .req_n(req_n),
        .addr_ready(ar_s), .base_addr(ba_s), .alloc_fail(af_s),
        .query_valid(query_valid & use_small), .query_m(query_m), .query_n(query_n),
        .query_idx(query_idx), .query_done(qd_s), .query_hit(qh_s), .query_base(qb_s),
        .query_cnt(qc_s), .busy(bs_s), .dir_count(dc_s)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_alloc(input string tag, input int m, input int n,
                            input logic exp_ok, input int exp_base, input int exp_lat);
        int   lat = -1;
        logic got_ok = 1'b0;
        req_m = 32'(m);
        req_n = 32'(n);
        req_valid = 1'b1;
        tick();
        for (int c = 1; c <= 60; c++) begin
            if (addr_ready || alloc_fail) begin
                lat = c;
                got_ok = addr_ready;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_grant"}, 32'(got_ok), 32'(exp_ok));
        if (exp_ok) chk({tag, "_base"}, 32'(base_addr), 32'(exp_base));
        wait_idle(tag);
    endtask

    task automatic do_query(input string tag, input int m, input int n, input int idx,
                            input logic exp_hit, input int exp_base, input int exp_cnt, input int exp_lat);
        int lat = -1;
        query_m = 32'(m);
        query_n = 32'(n);
        query_idx = 32'(idx);
        query_valid = 1'b1;
        tick();
        for (int c = 1; c <= 60; c++) begin
            if (query_done) begin
                lat = c;
                break;
            end
            tick();
        end
        query_valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(query_hit), 32'(exp_hit));
        chk({tag, "_base"}, 32'(query_base), 32'(exp_base));
        chk({tag, "_cnt"}, 32'(query_cnt), 32'(exp_cnt));
        wait_idle(tag);
    endtask

    int grants, gc, dc;
    logic [8:0] gbase, qb;
    logic qh;
    logic [2:0] qc;

    initial begin
        rst = 1'b1; clear_all = 1'b0; req_valid = 1'b0; query_valid = 1'b0; use_small = 1'b0;
        req_m = '0; req_n = '0; query_m = '0; query_n = '0; query_idx = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_addr_ready", 32'(addr_ready), 32'd0);
        chk("rst_alloc_fail", 32'(alloc_fail), 32'd0);
        chk("rst_query_done", 32'(query_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dir_count", 32'(dir_count), 32'd0);
        chk("rst_outs", {base_addr, query_base, query_cnt, query_hit}, 32'd0);

        // Reset asserted mid-SCAN drops the request
        req_m = 32'd2; req_n = 32'd3; req_valid = 1'b1;
        tick();
        repeat (4) tick();
        chk("midscan_busy_before", 32'(busy), 32'd1);
        rst = 1'b1; req_valid = 1'b0;
        tick();
        chk("midscan_busy_after", 32'(busy), 32'd0);
        rst = 1'b0;
        grants = 0;
        repeat (30) begin
            tick();
            if (addr_ready) grants++;
        end
        chk("midscan_no_grant", 32'(grants), 32'd0);
        chk("midscan_dir_count", 32'(dir_count), 32'd0);

        // Basic allocation sequence
        do_alloc("a1_2x3", 2, 3, 1'b1, 0, 18);
        do_alloc("a2_3x3", 3, 3, 1'b1, 6, 18);
        do_alloc("a3_2x3", 2, 3, 1'b1, 15, 18);
        chk("a3_dir_count", 32'(dir_count), 32'd3);

        // Queries against that directory
        do_query("q_2x3_2", 2, 3, 2, 1'b1, 15, 2, 17);
        do_query("q_4x4_1", 4, 4, 1, 1'b0, 0, 0, 17);
        do_query("q_3x3_2", 3, 3, 2, 1'b0, 0, 1, 17);

        // Round-robin overwrite of the full 2x3 shape
        do_alloc("a4_2x3_ovw", 2, 3, 1'b1, 0, 18);
        do_alloc("a5_2x3_ovw", 2, 3, 1'b1, 15, 18);
        chk("ovw_dir_count", 32'(dir_count), 32'd3);
        do_alloc("a6_1x1", 1, 1, 1'b1, 21, 18);
        chk("a6_dir_count", 32'(dir_count), 32'd4);

        // Out-of-range dimensions fail immediately
        do_alloc("bad_m6", 6, 2, 1'b0, 0, 1);
        do_alloc("bad_n0", 2, 0, 1'b0, 0, 1);
        chk("bad_dir_count", 32'(dir_count), 32'd4);

        // Request held across the grant yields exactly one grant
        req_m = 32'd1; req_n = 32'd2; req_valid = 1'b1;
        tick();
        grants = 0; gbase = '0;
        for (int c = 1; c <= 40; c++) begin
            if (addr_ready) begin
                grants++;
                gbase = base_addr;
            end
            tick();
        end
        chk("held_grants", 32'(grants), 32'd1);
        chk("held_base", 32'(gbase), 32'd22);
        chk("held_busy", 32'(busy), 32'd1);
        req_valid = 1'b0;
        wait_idle("held");
        chk("held_dir_count", 32'(dir_count), 32'd5);

        // Simultaneous request and query: allocation served first
        req_m = 32'd1; req_n = 32'd3; req_valid = 1'b1;
        query_m = 32'd2; query_n = 32'd3; query_idx = 32'd1; query_valid = 1'b1;
        gc = -1; dc = -1; gbase = '0; qb = '1; qh = 1'b0; qc = '0;
        tick();
        for (int c = 1; c <= 100; c++) begin
            if (addr_ready) begin
                gc = c;
                gbase = base_addr;
                req_valid = 1'b0;
            end
            if (query_done) begin
                dc = c;
                qh = query_hit;
                qb = query_base;
                qc = query_cnt;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        query_valid = 1'b0;
        chk("both_grant_cycle", 32'(gc), 32'd18);
        chk("both_grant_base", 32'(gbase), 32'd24);
        chk("both_order", 32'(dc > gc), 32'd1);
        chk("both_done_cycle", 32'(dc), 32'd37);
        chk("both_q_hit", 32'(qh), 32'd1);
        chk("both_q_base", 32'(qb), 32'd0);
        chk("both_q_cnt", 32'(qc), 32'd2);
        wait_idle("both");
        chk("both_dir_count", 32'(dir_count), 32'd6);

        // clear_all empties the directory and rewinds the free pointer
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        tick();
        chk("clr_dir_count", 32'(dir_count), 32'd0);
        do_alloc("clr_3x3", 3, 3, 1'b1, 0, 18);
        do_query("clr_q_3x3", 3, 3, 1, 1'b1, 0, 1, 17);

        // Small instance: memory and directory exhaustion
        use_small = 1'b1;
        tick();
        do_alloc("s_5x5", 5, 5, 1'b1, 0, 6);
        do_alloc("s_3x3_nomem", 3, 3, 1'b0, 0, 6);
        chk("s_dir_count1", 32'(dir_count), 32'd1);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        tick();
        chk("s_clr_dir_count", 32'(dir_count), 32'd0);
        do_alloc("s_1x1", 1, 1, 1'b1, 0, 6);
        do_alloc("s_1x2", 1, 2, 1'b1, 1, 6);
        do_alloc("s_1x3", 1, 3, 1'b1, 3, 6);
        do_alloc("s_1x4", 1, 4, 1'b1, 6, 6);
        do_alloc("s_2x1_nodir", 2, 1, 1'b0, 0, 6);
        chk("s_dir_count4", 32'(dir_count), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
